tpi_hs_port: RTL

TPI_HS_PORT -- requirements
Module: tpi_hs_port

---
 rtl/tpi_hs_port_if.sv | 37 +++
 rtl/tpi_hs_port.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tpi_hs_port_if.sv
// CPU bus, parallel ports and drive handshake signals of the tpi_hs_port block.
interface tpi_hs_port_if #(
  parameter int unsigned PA_W = 8,
  parameter int unsigned PB_W = 2,
  parameter int unsigned PC_W = 2
);
  logic            _cs;
  logic            _write;
  logic [2:0]      rs;
  logic [7:0]      data_in;
  logic [7:0]      data_out;
  logic            data_oe;
  logic [PA_W-1:0] pa_in;
  logic [PA_W-1:0] pa_out;
  logic [PA_W-1:0] pa_oe;
  logic [PB_W-1:0] pb_in;
  logic [PB_W-1:0] pb_out;
  logic [PB_W-1:0] pb_oe;
  logic [PC_W-1:0] pc_in;
  logic [PC_W-1:0] pc_out;
  logic [PC_W-1:0] pc_oe;
  logic            dav_n;
  logic            ack_n;
  logic            hs_busy;

  modport slave (
    input  _cs, _write, rs, data_in, pa_in, pb_in, pc_in, ack_n,
    output data_out, data_oe, pa_out, pa_oe, pb_out, pb_oe, pc_out, pc_oe,
           dav_n, hs_busy
  );

  modport master (
    output _cs, _write, rs, data_in, pa_in, pb_in, pc_in, ack_n,
    input  data_out, data_oe, pa_out, pa_oe, pb_out, pb_oe, pc_out, pc_oe,
           dav_n, hs_busy
  );
endinterface

// File: rtl/tpi_hs_port.sv
// Triple parallel port with a DAV/ACK output handshake engine driving port A.
module tpi_hs_port #(
  parameter int unsigned PA_W = 8,
  parameter int unsigned PB_W = 2,
  parameter int unsigned PC_W = 2,
  parameter int unsigned TMO  = 255
) (
  input  logic               clock,
  input  logic               _reset,
  tpi_hs_port_if.slave       port_if
);

  localparam int unsigned REG_W  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PC_LSB = REG_W - PC_W;
  localparam logic [REG_W-1:0] MASK_A = REG_W'((16'd1 << PA_W) - 16'd1);
  localparam logic [REG_W-1:0] MASK_B = REG_W'((16'd1 << PB_W) - 16'd1);
  localparam logic [REG_W-1:0] MASK_C = REG_W'(~((16'd1 << PC_LSB) - 16'd1));
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TMO - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_WAIT_LO = 2'd2,
    ST_WAIT_HI = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cs_prev_q;
  logic             ack_m_q, ack_s_q;

  logic [REG_W-1:0] pa_q, pa_d, pb_q, pb_d, pc_q, pc_d;
  logic [REG_W-1:0] ddra_q, ddra_d, ddrb_q, ddrb_d, ddrc_q, ddrc_d;
  logic             en_q, en_d, done_q, done_d, tmoerr_q, tmoerr_d;
  logic [REG_W-1:0] hsdata_q, hsdata_d;

  logic             dav_n_q, hs_busy_q;
  logic [REG_W-1:0] data_out_q;
  logic             data_oe_q;
  logic [PA_W-1:0]  pa_out_q, pa_oe_q;
  logic [PB_W-1:0]  pb_out_q, pb_oe_q;
  logic [PC_W-1:0]  pc_out_q, pc_oe_q;

  logic             access_c, wr_c, rd_c, busy_c, ovr_c, hs_start_c;
  logic             set_done_c, set_tmo_c;
  logic [REG_W-1:0] pin_a_c, pin_b_c, pin_c_c, read_c;

  // Access strobe: first clock of each _cs assertion.
  always_comb begin
    access_c   = 1'b0;
    access_c   = cs_prev_q && !port_if._cs;
    wr_c       = access_c && !port_if._write;
    rd_c       = access_c && port_if._write;
    busy_c     = (state_q != ST_IDLE);
    ovr_c      = en_q && busy_c;
    hs_start_c = wr_c && (port_if.rs == 3'd7) && en_q && !busy_c;
  end

  // Handshake FSM next-state, timeout counter and sticky-flag set requests.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    set_done_c = 1'b0;
    set_tmo_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (hs_start_c) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_WAIT_LO;
        cnt_d   = TMO_LOAD;
      end
      ST_WAIT_LO: begin
        if (!ack_s_q) begin
          state_d = ST_WAIT_HI;
          cnt_d   = TMO_LOAD;
        end else if (cnt_q == '0) begin
          state_d   = ST_IDLE;
          set_tmo_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_HI: begin
        if (ack_s_q) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          set_done_c = 1'b1;
        end else if (cnt_q == '0) begin
          state_d   = ST_IDLE;
          set_tmo_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Clearing EN mid-transfer abandons it without touching the flags.
    if (busy_c && !en_q) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      set_done_c = 1'b0;
      set_tmo_c  = 1'b0;
    end
  end

  // Register file write decode; FSM flag sets win over write-one-to-clear.
  always_comb begin
    pa_d     = pa_q;
    pb_d     = pb_q;
    pc_d     = pc_q;
    ddra_d   = ddra_q;
    ddrb_d   = ddrb_q;
    ddrc_d   = ddrc_q;
    en_d     = en_q;
    done_d   = done_q;
    tmoerr_d = tmoerr_q;
    hsdata_d = hsdata_q;
    if (wr_c) begin
      case (port_if.rs)
        3'd0: pa_d   = port_if.data_in & MASK_A;
        3'd1: pb_d   = port_if.data_in & MASK_B;
        3'd2: pc_d   = port_if.data_in & MASK_C;
        3'd3: ddra_d = port_if.data_in & MASK_A;
        3'd4: ddrb_d = port_if.data_in & MASK_B;
        3'd5: ddrc_d = port_if.data_in & MASK_C;
        3'd6: begin
          en_d = port_if.data_in[0];
          if (port_if.data_in[1]) done_d   = 1'b0;
          if (port_if.data_in[2]) tmoerr_d = 1'b0;
        end
        3'd7: if (!busy_c) hsdata_d = port_if.data_in;
        default: ;
      endcase
    end
    if (set_done_c) done_d   = 1'b1;
    if (set_tmo_c)  tmoerr_d = 1'b1;
  end

  // Read mux: pins for input bits, latch for output bits.
  always_comb begin
    pin_a_c = REG_W'(port_if.pa_in);
    pin_b_c = REG_W'(port_if.pb_in);
    pin_c_c = REG_W'(port_if.pc_in) << PC_LSB;
    read_c  = '0;
    case (port_if.rs)
      3'd0: read_c = (pin_a_c & ~ddra_q) | (pa_q & ddra_q);
      3'd1: read_c = (pin_b_c & ~ddrb_q) | (pb_q & ddrb_q);
      3'd2: read_c = (pin_c_c & ~ddrc_q) | (pc_q & ddrc_q);
      3'd3: read_c = ddra_q;
      3'd4: read_c = ddrb_q;
      3'd5: read_c = ddrc_q;
      3'd6: read_c = {busy_c, 4'b0000, tmoerr_q, done_q, en_q};
      3'd7: read_c = (en_q && !busy_c) ? pin_a_c : hsdata_q;
      default: ;
    endcase
  end

  // State, registers, synchroniser and registered outputs.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cs_prev_q  <= 1'b1;
      ack_m_q    <= 1'b1;
      ack_s_q    <= 1'b1;
      pa_q       <= '0;
      pb_q       <= '0;
      pc_q       <= '0;
      ddra_q     <= '0;
      ddrb_q     <= '0;
      ddrc_q     <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      tmoerr_q   <= 1'b0;
      hsdata_q   <= '0;
      dav_n_q    <= 1'b1;
      hs_busy_q  <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      pa_out_q   <= '0;
      pa_oe_q    <= '0;
      pb_out_q   <= '0;
      pb_oe_q    <= '0;
      pc_out_q   <= '0;
      pc_oe_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_prev_q  <= port_if._cs;
      ack_m_q    <= port_if.ack_n;
      ack_s_q    <= ack_m_q;
      pa_q       <= pa_d;
      pb_q       <= pb_d;
      pc_q       <= pc_d;
      ddra_q     <= ddra_d;
      ddrb_q     <= ddrb_d;
      ddrc_q     <= ddrc_d;
      en_q       <= en_d;
      done_q     <= done_d;
      tmoerr_q   <= tmoerr_d;
      hsdata_q   <= hsdata_d;
      dav_n_q    <= (state_d != ST_WAIT_LO);
      hs_busy_q  <= (state_d != ST_IDLE);
      if (rd_c) data_out_q <= read_c;
      if (rd_c)             data_oe_q <= 1'b1;
      else if (port_if._cs) data_oe_q <= 1'b0;
      pa_out_q   <= ovr_c ? hsdata_q[PA_W-1:0] : pa_q[PA_W-1:0];
      pa_oe_q    <= ovr_c ? {PA_W{1'b1}} : ddra_q[PA_W-1:0];
      pb_out_q   <= pb_q[PB_W-1:0];
      pb_oe_q    <= ddrb_q[PB_W-1:0];
      pc_out_q   <= pc_q[REG_W-1:PC_LSB];
      pc_oe_q    <= ddrc_q[REG_W-1:PC_LSB];
    end
  end

  assign port_if.data_out = data_out_q;
  assign port_if.data_oe  = data_oe_q;
  assign port_if.pa_out   = pa_out_q;
  assign port_if.pa_oe    = pa_oe_q;
  assign port_if.pb_out   = pb_out_q;
  assign port_if.pb_oe    = pb_oe_q;
  assign port_if.pc_out   = pc_out_q;
  assign port_if.pc_oe    = pc_oe_q;
  assign port_if.dav_n    = dav_n_q;
  assign port_if.hs_busy  = hs_busy_q;

endmodule
